line_word_streamer: RTL and testbench

- Parametrised successor to the single-cycle line word selector.
- Captures one cache line, then streams its words out one per accepted handshake over a valid/ready interface.
- Start word is selectable. Two orders: critical-word-first with wrap-around, or linear to end of line.
- Sits between the cache datapath and narrower consumers (writeback bus, prefetch/fill forwarding, debug readout).

---
 rtl/line_word_streamer.sv | 92 +++++++++
 tb/tb_line_word_streamer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/line_word_streamer.sv
// line_word_streamer: captures one cache line and streams its words out over a
// valid/ready interface, starting at a selectable word offset and running either
// critical-word-first with wrap-around or linearly to the end of the line.
module line_word_streamer #(
   parameter int WORD_W = 16,
   parameter int WORDS  = 8,
   parameter int OFF_W  = $clog2(WORDS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   output logic                    load_ready,
   input  logic [WORD_W*WORDS-1:0] line_in,
   input  logic [OFF_W-1:0]        start_off,
   input  logic                    wrap_mode,
   input  logic                    abort,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WORD_W-1:0]       out_word,
   output logic [OFF_W-1:0]        out_off,
   output logic                    out_last,
   output logic                    done
);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // remaining must be able to hold the full WORDS count, hence one extra bit
   localparam logic [OFF_W:0] FULL_CNT = (OFF_W+1)'(WORDS);
   localparam logic [OFF_W:0] ONE_CNT  = (OFF_W+1)'(1);

   state_t            state;
   logic [WORD_W-1:0] line_q [WORDS];
   logic [OFF_W-1:0]  idx;
   logic [OFF_W:0]    remaining;
   logic              xfer;

   // Handshake and output decode; out_word comes only from the captured line
   always_comb begin
      load_ready = (state == IDLE);
      out_valid  = (state == STREAM);
      out_last   = (state == STREAM) && (remaining == ONE_CNT);
      out_word   = line_q[idx];
      out_off    = idx;
      xfer       = out_valid && out_ready;
   end

   // Stream control FSM: capture on load, step on transfer, end on last word or abort
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         remaining <= '0;
         done      <= 1'b0;
         for (int i = 0; i < WORDS; i++) begin
            line_q[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  for (int i = 0; i < WORDS; i++) begin
                     line_q[i] <= line_in[WORD_W*i +: WORD_W];
                  end
                  idx       <= start_off;
                  remaining <= wrap_mode ? FULL_CNT : (FULL_CNT - {1'b0, start_off});
                  state     <= STREAM;
               end
            end
            STREAM: begin
               if (abort) begin
                  // a transfer in this cycle still reaches the consumer, but the stream ends silently
                  state <= IDLE;
               end else if (xfer) begin
                  // idx wraps naturally at WORDS because WORDS is a power of two
                  idx       <= idx + 1'b1;
                  remaining <= remaining - ONE_CNT;
                  if (remaining == ONE_CNT) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_word_streamer.sv
// Directed testbench for line_word_streamer: default 8x16 instance plus a 4x32 instance.
module tb_line_word_streamer;

   logic         clk = 1'b0;
   logic         rst;

   // 8-word x 16-bit instance
   logic         load, wrap_mode, abort, out_ready;
   logic [127:0] line_in;
   logic [2:0]   start_off;
   logic         load_ready, out_valid, out_last, done;
   logic [15:0]  out_word;
   logic [2:0]   out_off;

   // 4-word x 32-bit instance
   logic         load_s, wrap_mode_s, abort_s, out_ready_s;
   logic [127:0] line_in_s;
   logic [1:0]   start_off_s;
   logic         load_ready_s, out_valid_s, out_last_s, done_s;
   logic [31:0]  out_word_s;
   logic [1:0]   out_off_s;

   int checks = 0;
   int errors = 0;

   logic [127:0] line_a, line_b, line_c;

   int offs_wrap5 [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
   int offs_lin5  [3] = '{5, 6, 7};

   line_word_streamer #(.WORD_W(16), .WORDS(8)) dut (
      .clk(clk), .rst(rst), .load(load), .load_ready(load_ready), .line_in(line_in),
      .start_off(start_off), .wrap_mode(wrap_mode), .abort(abort), .out_valid(out_valid),
      .out_ready(out_ready), .out_word(out_word), .out_off(out_off), .out_last(out_last),
      .done(done)
   );

   line_word_streamer #(.WORD_W(32), .WORDS(4)) dut_s (
      .clk(clk), .rst(rst), .load(load_s), .load_ready(load_ready_s), .line_in(line_in_s),
      .start_off(start_off_s), .wrap_mode(wrap_mode_s), .abort(abort_s), .out_valid(out_valid_s),
      .out_ready(out_ready_s), .out_word(out_word_s), .out_off(out_off_s), .out_last(out_last_s),
      .done(done_s)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8; i++) begin
         line_a[16*i +: 16] = 16'hA000 + 16'(i);
         line_b[16*i +: 16] = 16'h5B00 + 16'(i);
      end
      line_c = '0;
      for (int i = 0; i < 4; i++) line_c[32*i +: 32] = 32'hC0DE0000 + 32'(i);

      rst = 1'b1; load = 0; wrap_mode = 0; abort = 0; out_ready = 0; line_in = '0; start_off = '0;
      load_s = 0; wrap_mode_s = 0; abort_s = 0; out_ready_s = 0; line_in_s = '0; start_off_s = '0;
      tick(); tick();
      rst = 1'b0;

      // reset state held over idle cycles
      tick(); tick(); tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_load_ready", load_ready, 1);
      chk("rst_word", out_word, 0);
      chk("rst_off", out_off, 0);
      chk("rst_last", out_last, 0);
      chk("rst_s_valid", out_valid_s, 0);
      chk("rst_s_word", out_word_s, 0);

      // wrap stream from offset 5
      line_in = line_a; start_off = 3'd5; wrap_mode = 1; out_ready = 1; load = 1;
      tick();
      load = 0;
      chk("w5_busy", load_ready, 0);
      for (int k = 0; k < 8; k++) begin
         chk("w5_valid", out_valid, 1);
         chk("w5_word", out_word, 64'(16'hA000 + 16'(offs_wrap5[k])));
         chk("w5_off", out_off, 64'(offs_wrap5[k]));
         chk("w5_last", out_last, (k == 7) ? 1 : 0);
         chk("w5_nodone", done, 0);
         tick();
      end
      chk("w5_done", done, 1);
      chk("w5_valid_end", out_valid, 0);
      tick();
      chk("w5_done_pulse", done, 0);

      // linear stream from offset 5
      start_off = 3'd5; wrap_mode = 0; load = 1;
      tick();
      load = 0;
      for (int k = 0; k < 3; k++) begin
         chk("l5_word", out_word, 64'(16'hA000 + 16'(offs_lin5[k])));
         chk("l5_off", out_off, 64'(offs_lin5[k]));
         chk("l5_last", out_last, (k == 2) ? 1 : 0);
         tick();
      end
      chk("l5_done", done, 1);
      chk("l5_valid_end", out_valid, 0);
      chk("l5_ready_in_done", load_ready, 1);

      // back-to-back load in the done cycle: linear from 0 with throttled out_ready
      start_off = 3'd0; wrap_mode = 0; load = 1;
      tick();
      load = 0;
      chk("bb_valid", out_valid, 1);
      chk("bb_done_low", done, 0);
      n = 0;
      for (int c = 0; c < 40 && n < 8; c++) begin
         chk("thr_valid", out_valid, 1);
         chk("thr_word", out_word, 64'(16'hA000 + 16'(n)));
         chk("thr_off", out_off, 64'(n));
         chk("thr_last", out_last, (n == 7) ? 1 : 0);
         out_ready = (c % 3 == 0);
         load = (c == 4);
         start_off = (c == 4) ? 3'd3 : 3'd0;
         tick();
         if (out_ready) n++;
      end
      load = 0; out_ready = 1;
      chk("thr_count", n, 8);
      chk("thr_done", done, 1);
      chk("thr_valid_end", out_valid, 0);
      tick();

      // abort after three transfers, then reload immediately
      start_off = 3'd2; wrap_mode = 1; load = 1;
      tick();
      load = 0;
      for (int k = 0; k < 3; k++) begin
         chk("ab_word", out_word, 64'(16'hA002 + 16'(k)));
         tick();
      end
      chk("ab_word4", out_word, 64'(16'hA005));
      abort = 1;
      tick();
      abort = 0;
      chk("ab_valid", out_valid, 0);
      chk("ab_nodone", done, 0);
      chk("ab_ready", load_ready, 1);
      line_in = line_b; start_off = 3'd6; wrap_mode = 0; load = 1; abort = 1;
      tick();
      load = 0; abort = 0;
      chk("rl_word0", out_word, 64'(16'h5B06));
      chk("rl_off0", out_off, 6);
      chk("rl_last0", out_last, 0);
      tick();
      chk("rl_word1", out_word, 64'(16'h5B07));
      chk("rl_last1", out_last, 1);
      tick();
      chk("rl_done", done, 1);
      tick();

      // reset mid-stream
      line_in = line_a; start_off = 3'd1; wrap_mode = 1; load = 1;
      tick();
      load = 0;
      tick(); tick();
      chk("mr_word", out_word, 64'(16'hA003));
      rst = 1;
      tick();
      rst = 0;
      chk("mr_valid", out_valid, 0);
      chk("mr_done", done, 0);
      chk("mr_ready", load_ready, 1);
      chk("mr_word_clr", out_word, 0);
      tick();
      chk("mr_done2", done, 0);

      // 4x32 instance: single-word stream at the last offset
      line_in_s = line_c; start_off_s = 2'd3; wrap_mode_s = 0; out_ready_s = 1; load_s = 1;
      tick();
      load_s = 0;
      chk("sw_valid", out_valid_s, 1);
      chk("sw_word", out_word_s, 64'(32'hC0DE0003));
      chk("sw_off", out_off_s, 3);
      chk("sw_last", out_last_s, 1);
      tick();
      chk("sw_done", done_s, 1);
      chk("sw_valid_end", out_valid_s, 0);
      tick();
      chk("sw_done_pulse", done_s, 0);

      // 4x32 instance: wrap from 0 behaves as a linear full line
      start_off_s = 2'd0; wrap_mode_s = 1; load_s = 1;
      tick();
      load_s = 0;
      for (int k = 0; k < 4; k++) begin
         chk("w0_word", out_word_s, 64'(32'hC0DE0000 + 32'(k)));
         chk("w0_last", out_last_s, (k == 3) ? 1 : 0);
         tick();
      end
      chk("w0_done", done_s, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
